// File: rtl/sdcard_multislot_power_ctrl.sv
// Multi-slot SD card power sequencer: per-slot OFF/RAMP/ON/SWITCH/DISCH/FAULT FSM
// with a one-slot-at-a-time inrush limit. Optional auto-retry from FAULT via SDPWR_RETRY_EN.
module sdcard_multislot_power_ctrl #(
  parameter int NUM_SLOTS        = 2,
  parameter int STARTUP_CYCLES   = 256,
  parameter int SETTLE_CYCLES    = 128,
  parameter int DISCHARGE_CYCLES = 64,
  parameter int FAULT_THRESHOLD  = 16,
  parameter int RETRY_MAX        = 3
) (
  input  logic                 PCLK_i,
  input  logic                 PRESET_i,
  input  logic [NUM_SLOTS-1:0] pwr_req_i,
  input  logic [NUM_SLOTS-1:0] vdd_sel_req_i,
  input  logic [NUM_SLOTS-1:0] pgood_i,
  input  logic [NUM_SLOTS-1:0] ocp_i,
  input  logic [NUM_SLOTS-1:0] fault_clear_i,
  output logic [NUM_SLOTS-1:0] sd_pwr_en_o,
  output logic [NUM_SLOTS-1:0] sd_vdd_sel_o,
  output logic [NUM_SLOTS-1:0] power_good_o,
  output logic [NUM_SLOTS-1:0] power_fault_o,
  output logic                 ramp_busy_o
);

  localparam int MAX_A    = (STARTUP_CYCLES > SETTLE_CYCLES) ? STARTUP_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B    = (DISCHARGE_CYCLES > FAULT_THRESHOLD) ? DISCHARGE_CYCLES : FAULT_THRESHOLD;
  localparam int MAX_P    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] RAMP_END = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] SET_END  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DIS_END  = CW'(DISCHARGE_CYCLES - 1);
  localparam logic [CW-1:0] THR_END  = CW'(FAULT_THRESHOLD - 1);

  if (NUM_SLOTS < 1 || NUM_SLOTS > 4 || RETRY_MAX < 0) begin : g_param_check
    $error("sdcard_multislot_power_ctrl: NUM_SLOTS must be 1..4 and RETRY_MAX >= 0");
  end

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RAMP   = 3'd1,
    S_ON     = 3'd2,
    S_SWITCH = 3'd3,
    S_DISCH  = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  state_e              state_q [NUM_SLOTS];
  state_e              state_d [NUM_SLOTS];
  logic [CW-1:0]       cnt_q   [NUM_SLOTS];
  logic [CW-1:0]       cnt_d   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] vsel_q, vsel_d;
  logic [NUM_SLOTS-1:0] pwr_en_q, pgood_q, fault_q;
  logic                 ramp_busy_q;
  logic                 ramp_free;
  logic                 granted;

`ifdef SDPWR_RETRY_EN
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  logic [RW-1:0] retry_q  [NUM_SLOTS];
  logic [RW-1:0] retry_d  [NUM_SLOTS];
  logic [CW-1:0] on_cnt_q [NUM_SLOTS];
  logic [CW-1:0] on_cnt_d [NUM_SLOTS];
`endif

  always_comb begin
    // The ramp slot is free for a new grant on the same edge the current ramp slot leaves.
    ramp_free = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state_q[i] == S_RAMP && !(ocp_i[i] || !pwr_req_i[i] || cnt_q[i] == RAMP_END)) begin
        ramp_free = 1'b0;
      end
    end

    granted = 1'b0;
    vsel_d  = vsel_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
`ifdef SDPWR_RETRY_EN
      retry_d[i] = retry_q[i];
`endif

      unique case (state_q[i])
        S_OFF: begin
          if (pwr_req_i[i] && ramp_free && !granted) begin
            state_d[i] = S_RAMP;
            granted    = 1'b1;
          end
        end
        S_RAMP: begin
          if (ocp_i[i])                state_d[i] = S_FAULT;
          else if (!pwr_req_i[i])      state_d[i] = S_DISCH;
          else if (cnt_q[i] == RAMP_END) state_d[i] = pgood_i[i] ? S_ON : S_FAULT;
        end
        S_ON: begin
          // In ON the counter tracks consecutive pgood-low cycles.
          cnt_d[i] = pgood_i[i] ? '0 : ((cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1);
          if (ocp_i[i] || (!pgood_i[i] && cnt_q[i] == THR_END)) begin
            state_d[i] = S_FAULT;
          end else if (!pwr_req_i[i]) begin
            state_d[i] = S_DISCH;
          end else if (vdd_sel_req_i[i] != vsel_q[i]) begin
            state_d[i] = S_SWITCH;
            vsel_d[i]  = vdd_sel_req_i[i];
          end
        end
        S_SWITCH: begin
          if (ocp_i[i])                 state_d[i] = S_FAULT;
          else if (!pwr_req_i[i])       state_d[i] = S_DISCH;
          else if (cnt_q[i] == SET_END) state_d[i] = pgood_i[i] ? S_ON : S_FAULT;
        end
        S_DISCH: begin
          if (cnt_q[i] == DIS_END) state_d[i] = S_OFF;
        end
        S_FAULT: begin
          if (fault_clear_i[i]) begin
            state_d[i] = S_DISCH;
`ifdef SDPWR_RETRY_EN
            retry_d[i] = '0;
          end else if (cnt_q[i] == DIS_END && retry_q[i] < RETRY_LIM) begin
            state_d[i] = S_DISCH;
            retry_d[i] = retry_q[i] + 1'b1;
`endif
          end
        end
        default: state_d[i] = S_OFF;
      endcase

      if (state_d[i] != state_q[i]) cnt_d[i] = '0;
      if (state_d[i] != S_ON && state_d[i] != S_SWITCH) vsel_d[i] = 1'b0;

`ifdef SDPWR_RETRY_EN
      on_cnt_d[i] = '0;
      if (state_q[i] == S_ON && state_d[i] == S_ON) begin
        on_cnt_d[i] = (on_cnt_q[i] == CNT_MAX) ? on_cnt_q[i] : on_cnt_q[i] + 1'b1;
      end
      if (!pwr_req_i[i] || (state_q[i] == S_ON && on_cnt_q[i] == RAMP_END)) retry_d[i] = '0;
`endif
    end
  end

  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
`ifdef SDPWR_RETRY_EN
        retry_q[i]  <= '0;
        on_cnt_q[i] <= '0;
`endif
      end
      vsel_q      <= '0;
      pwr_en_q    <= '0;
      pgood_q     <= '0;
      fault_q     <= '0;
      ramp_busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        pwr_en_q[i] <= (state_d[i] == S_RAMP) || (state_d[i] == S_ON) || (state_d[i] == S_SWITCH);
        pgood_q[i]  <= (state_d[i] == S_ON);
        fault_q[i]  <= (state_d[i] == S_FAULT);
`ifdef SDPWR_RETRY_EN
        retry_q[i]  <= retry_d[i];
        on_cnt_q[i] <= on_cnt_d[i];
`endif
      end
      vsel_q      <= vsel_d;
      ramp_busy_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (state_d[i] == S_RAMP) ramp_busy_q <= 1'b1;
      end
    end
  end

  assign sd_pwr_en_o   = pwr_en_q;
  assign sd_vdd_sel_o  = vsel_q;
  assign power_good_o  = pgood_q;
  assign power_fault_o = fault_q;
  assign ramp_busy_o   = ramp_busy_q;

endmodule

// File: tb/tb_sdcard_multislot_power_ctrl.sv
// Bench for sdcard_multislot_power_ctrl (2 slots, short timings); vector table plus
// hand-written sequences for arbitration, reset-in-SWITCH and stuck-pgood retry behaviour.
module tb_sdcard_multislot_power_ctrl;
  localparam int W = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pwr_req, vsel_req, pgood, ocp, fclr;
  logic [1:0] pwr_en, vdd_sel, pgood_o, pfault;
  logic       ramp_busy;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] req, vsel, pg, ocp, fclr;
    int         cycles;
    logic [1:0] en, vs, pgo, pf;
    logic       rb;
    string      name;
  } vec_t;

  vec_t vecs[24];

  sdcard_multislot_power_ctrl #(
    .NUM_SLOTS(2), .STARTUP_CYCLES(8), .SETTLE_CYCLES(4),
    .DISCHARGE_CYCLES(4), .FAULT_THRESHOLD(3), .RETRY_MAX(2)
  ) dut (
    .PCLK_i(clk), .PRESET_i(rst),
    .pwr_req_i(pwr_req), .vdd_sel_req_i(vsel_req), .pgood_i(pgood),
    .ocp_i(ocp), .fault_clear_i(fclr),
    .sd_pwr_en_o(pwr_en), .sd_vdd_sel_o(vdd_sel), .power_good_o(pgood_o),
    .power_fault_o(pfault), .ramp_busy_o(ramp_busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, v, g, o, f);
    pwr_req = r; vsel_req = v; pgood = g; ocp = o; fclr = f;
  endtask

  task automatic push_exp(input logic [1:0] en, vs, pg, pf, input logic rb);
    exp_q.push_back({en, vs, pg, pf, rb});
  endtask

  task automatic check(input string name);
    logic [W-1:0] got, exp;
    got = {pwr_en, vdd_sel, pgood_o, pfault, ramp_busy};
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no expected entry queued, got %b", name, got);
    end else begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s: got en/vs/pg/pf/rb=%b required %b", name, got, exp);
      end
    end
  endtask

  task automatic set_vec(input int k, input logic [1:0] r, v, g, o, f, input int c,
                         input logic [1:0] en, vs, pg, pf, input logic rb, input string nm);
    vecs[k].req = r; vecs[k].vsel = v; vecs[k].pg = g; vecs[k].ocp = o; vecs[k].fclr = f;
    vecs[k].cycles = c; vecs[k].en = en; vecs[k].vs = vs; vecs[k].pgo = pg;
    vecs[k].pf = pf; vecs[k].rb = rb; vecs[k].name = nm;
  endtask

  initial begin
    int rb_edges;
    logic rb_prev;
    int exp_ramps;

    //            req    vsel   pg     ocp    fclr  cyc  en     vs     pgo    pf    rb
    set_vec( 0, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b01, 2'b10, 2'b00, 0, "switch_enter");
    set_vec( 1, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 3, 2'b11, 2'b01, 2'b10, 2'b00, 0, "switch_hold");
    set_vec( 2, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b01, 2'b11, 2'b00, 0, "switch_done");
    set_vec( 3, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2, 2'b11, 2'b01, 2'b11, 2'b00, 0, "pg_low2");
    set_vec( 4, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b01, 2'b11, 2'b00, 0, "pg_recover");
    set_vec( 5, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2, 2'b11, 2'b01, 2'b11, 2'b00, 0, "pg_low2b");
    set_vec( 6, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 1, 2'b10, 2'b00, 2'b10, 2'b01, 0, "pg_low3_fault");
    set_vec( 7, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 3, 2'b10, 2'b00, 2'b10, 2'b01, 0, "fault_hold");
    set_vec( 8, 2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, "clr0_disch");
    set_vec( 9, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 3, 2'b10, 2'b00, 2'b10, 2'b00, 0, "disch0_hold");
    set_vec(10, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, "off0");
    set_vec(11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b00, 2'b10, 2'b00, 1, "reramp0");
    set_vec(12, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 7, 2'b11, 2'b00, 2'b10, 2'b00, 1, "ramp0_hold");
    set_vec(13, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b00, 2'b11, 2'b00, 0, "ramp0_on");
    set_vec(14, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 1, 2'b01, 2'b00, 2'b01, 2'b00, 0, "on1_disch");
    set_vec(15, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 4, 2'b01, 2'b00, 2'b01, 2'b00, 0, "off1");
    set_vec(16, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b00, 2'b01, 2'b00, 1, "ramp1");
    set_vec(17, 2'b11, 2'b00, 2'b11, 2'b10, 2'b00, 1, 2'b01, 2'b00, 2'b01, 2'b10, 0, "ocp1_fault");
    set_vec(18, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2, 2'b01, 2'b00, 2'b01, 2'b10, 0, "fault1_hold");
    set_vec(19, 2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 1, 2'b01, 2'b00, 2'b01, 2'b00, 0, "clr1_disch");
    set_vec(20, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 3, 2'b01, 2'b00, 2'b01, 2'b00, 0, "disch1_hold");
    set_vec(21, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1, 2'b01, 2'b00, 2'b01, 2'b00, 0, "off1b");
    set_vec(22, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b00, 2'b01, 2'b00, 1, "reramp1");
    set_vec(23, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 1, 2'b01, 2'b00, 2'b01, 2'b00, 0, "ramp1_abort");

    // Reset
    rst = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step(2);
    push_exp(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    check("reset_state");

    // Simultaneous requests: slot0 ramps first, slot1 follows without a gap
    rst = 1'b0;
    drive(2'b11, 2'b00, 2'b11, 2'b00, 2'b00);
    for (int k = 1; k <= 17; k++) begin
      step(1);
      push_exp({(k >= 9), 1'b1}, 2'b00, {(k >= 17), (k >= 9)}, 2'b00, (k <= 16));
      check($sformatf("dual_ramp_c%0d", k));
    end

    // Table of single-function vectors from the both-ON state
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].req, vecs[i].vsel, vecs[i].pg, vecs[i].ocp, vecs[i].fclr);
      step(vecs[i].cycles);
      push_exp(vecs[i].en, vecs[i].vs, vecs[i].pgo, vecs[i].pf, vecs[i].rb);
      check(vecs[i].name);
    end

    // Reset asserted in the middle of a voltage switch
    drive(2'b11, 2'b01, 2'b11, 2'b00, 2'b00);
    step(1);
    push_exp(2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
    check("mid_switch_pre");
    step(1);
    rst = 1'b1;
    step(1);
    push_exp(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    check("reset_mid_switch");
    rst = 1'b0;
    step(1);
    push_exp(2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    check("first_cycle_after_reset");
    drive(2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    step(1);
    push_exp(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    check("ramp_abort_disch");
    step(5);
    push_exp(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    check("back_to_off");

    // Stuck-low pgood on slot0: count ramp attempts before FAULT is held
`ifdef SDPWR_RETRY_EN
    exp_ramps = 3;
`else
    exp_ramps = 1;
`endif
    drive(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    rb_edges = 0;
    rb_prev  = ramp_busy;
    for (int c = 0; c < 120; c++) begin
      step(1);
      if (ramp_busy && !rb_prev) rb_edges++;
      rb_prev = ramp_busy;
    end
    n_cmp++;
    if (rb_edges != exp_ramps) begin
      n_err++;
      $display("FAIL stuck_pgood_ramps: got %0d ramp attempts required %0d", rb_edges, exp_ramps);
    end
    push_exp(2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    check("stuck_pgood_fault_held");

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdcard_multislot_power_ctrl.md
SDCARD_MULTISLOT_POWER_CTRL -- requirements
Module: sdcard_multislot_power_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLOTS, 2, number of independently powered card slots (1..4).
REQ-002 SHALL have parameter STARTUP_CYCLES, 256, ramp duration per slot.
REQ-003 SHALL have parameter SETTLE_CYCLES, 128, voltage-switch settle duration.
REQ-004 SHALL have parameter DISCHARGE_CYCLES, 64, forced off time before re-power.
REQ-005 SHALL have parameter FAULT_THRESHOLD, 16, consecutive pgood-low cycles that declare a fault in ON.
REQ-006 SHALL have parameter RETRY_MAX, 3, auto-retry limit (used only with SDPWR_RETRY_EN).
REQ-007 SHALL have ports: PCLK_i in 1 clock; PRESET_i in 1 synchronous active-high reset; one clock, no other clock domains.
REQ-008 SHALL have ports: pwr_req_i in NUM_SLOTS power request; vdd_sel_req_i in NUM_SLOTS 1=1.8V, 0=3.3V; pgood_i in NUM_SLOTS external regulator good; ocp_i in NUM_SLOTS overcurrent; fault_clear_i in NUM_SLOTS fault acknowledge pulse.
REQ-009 SHALL have ports: sd_pwr_en_o out NUM_SLOTS; sd_vdd_sel_o out NUM_SLOTS; power_good_o out NUM_SLOTS; power_fault_o out NUM_SLOTS; ramp_busy_o out 1 (any slot in RAMP).

Function
REQ-010 Each slot SHALL run an independent FSM: OFF, RAMP, ON, SWITCH, DISCH, FAULT; all outputs registered.
REQ-011 Inrush limit: at most one slot in RAMP at any time; OFF slot with pwr_req_i=1 enters RAMP only when no slot is in RAMP; simultaneous requests granted lowest index first.
REQ-012 OFF: sd_pwr_en_o=0, sd_vdd_sel_o=0, power_good_o=0, power_fault_o=0.
REQ-013 RAMP: sd_pwr_en_o=1, sd_vdd_sel_o=0 (always ramp at 3.3V); lasts exactly STARTUP_CYCLES cycles; at end pgood_i=1 -> ON, else -> FAULT.
REQ-014 ON: power_good_o=1, sd_pwr_en_o=1; pwr_req_i=0 -> DISCH; vdd_sel_req_i != sd_vdd_sel_o -> SWITCH; fault check has priority over both.
REQ-015 ON fault: ocp_i=1 in any state with sd_pwr_en_o=1 -> FAULT next cycle; in ON, pgood_i low FAULT_THRESHOLD consecutive cycles -> FAULT; counter clears on any pgood_i=1 cycle.
REQ-016 SWITCH: sd_vdd_sel_o takes vdd_sel_req_i on entry, power_good_o=0, sd_pwr_en_o=1; lasts SETTLE_CYCLES; at end pgood_i=1 -> ON else FAULT; request changes during SWITCH ignored until ON.
REQ-017 DISCH: sd_pwr_en_o=0, sd_vdd_sel_o=0, power_good_o=0; lasts DISCHARGE_CYCLES then -> OFF; pwr_req_i ignored meanwhile.
REQ-018 FAULT: sd_pwr_en_o=0, sd_vdd_sel_o=0, power_good_o=0, power_fault_o=1; fault_clear_i=1 -> DISCH and retry count cleared.
REQ-019 pwr_req_i=0 during RAMP or SWITCH SHALL abort to DISCH next cycle (ocp_i takes priority -> FAULT).
REQ-020 Counters SHALL be $clog2(max parameter+1) bits, saturate, never wrap; cleared on every state entry.
REQ-021 ramp_busy_o SHALL equal OR of slots in RAMP, registered with state.

Reset
REQ-022 PRESET_i=1 at PCLK_i edge SHALL force all slots to OFF, all counters and retry counts to 0, all outputs 0, including mid-RAMP or mid-SWITCH.
REQ-023 First cycle after reset release SHALL evaluate requests per REQ-011.

Configuration
REQ-024 Macro SDPWR_RETRY_EN: defined -> FAULT auto-exits to DISCH after DISCHARGE_CYCLES if slot retry count < RETRY_MAX, incrementing it; at RETRY_MAX stays in FAULT until fault_clear_i; count cleared on reaching ON for STARTUP_CYCLES cycles or on pwr_req_i=0.
REQ-025 Without SDPWR_RETRY_EN: FAULT exits only on fault_clear_i; no retry counter logic present.

Verification (NUM_SLOTS=2, STARTUP=8, SETTLE=4, DISCHARGE=4, THRESHOLD=3, RETRY_MAX=2)
REQ-026 pwr_req_i=2'b11 same cycle, pgood_i=11 -> slot0 RAMP 8 cycles then ON; slot1 RAMP starts the cycle slot0 leaves RAMP; ramp_busy_o high 16 consecutive cycles.
REQ-027 Slot0 ON, vdd_sel_req_i[0]=1 -> SWITCH, sd_vdd_sel_o[0]=1, power_good_o[0]=0 for 4 cycles, then ON.
REQ-028 Slot0 ON, pgood_i[0] low 2 cycles then high -> stays ON; low 3 cycles -> FAULT, sd_pwr_en_o[0]=0, power_fault_o[0]=1.
REQ-029 ocp_i[1]=1 in RAMP -> FAULT next cycle; fault_clear_i[1] -> DISCH 4 cycles -> OFF -> RAMP if pwr_req_i[1]=1.
REQ-030 With SDPWR_RETRY_EN, pgood_i[0] stuck 0 -> exactly 2 auto-retries then FAULT held until fault_clear_i; without macro -> FAULT held after first ramp.
REQ-031 PRESET_i asserted mid-SWITCH -> all outputs 0 next cycle, slot OFF.
